// File: rtl/gpio_bus_sequencer_pkg.sv
// Shared types and constants for the GPIO bus sequencer: FSM state encoding,
// register address map and the default data bus width.
package gpio_pkg;

   localparam int GPIO_N = 4;

   localparam logic [1:0] ADDR_OUT = 2'd0;
   localparam logic [1:0] ADDR_DIR = 2'd1;
   localparam logic [1:0] ADDR_PIN = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_STROBE,
      W_HOLD,
      R_DRIVE,
      R_SAMPLE,
      RESP
   } state_t;

endpackage

// File: rtl/gpio_bus_sequencer_if.sv
// CPU request/response channel, shared data bus and peripheral strobes of the
// GPIO bus sequencer; master is the sequencer, slave is the CPU plus peripheral side.
interface gpio_bus_sequencer_if #(
   parameter int N = gpio_pkg::GPIO_N
);

   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [1:0]   req_addr;
   logic [N-1:0] req_wdata;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_rdata;
   logic         rsp_err;

   logic [N-1:0] bus_out;
   logic         bus_oe;
   logic [N-1:0] bus_in;

   logic         read_in;
   logic         load_out;
   logic         load_dir;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output bus_out, bus_oe,
      input  bus_in,
      output read_in, load_out, load_dir
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  bus_out, bus_oe,
      output bus_in,
      input  read_in, load_out, load_dir
   );

endinterface

// File: rtl/gpio_bus_sequencer.sv
// Turns CPU register requests into READ_IN / LOAD_OUT / LOAD_DIR strobe sequences on the
// GPIO peripheral bus. Optional macro GPIO_SHADOW_READBACK_EN adds shadow readback of addr 0/1.
module gpio_bus_sequencer
   import gpio_pkg::*;
#(
   parameter int N = GPIO_N
) (
   input logic                  clock,
   input logic                  reset,
   gpio_bus_sequencer_if.master sif
);

   state_t       state;
   state_t       next_state;

   logic [1:0]   addr_q;
   logic [N-1:0] wdata_q;
   logic [N-1:0] wdata_cur;

   logic         accept;
   logic         is_write_ok;
   logic         is_pin_read;
   logic         shadow_hit;
   logic [N-1:0] shadow_rdata;

   logic         req_ready_q;
   logic         rsp_valid_q;
   logic         rsp_err_q;
   logic [N-1:0] rsp_rdata_q;
   logic [N-1:0] bus_out_q;
   logic         bus_oe_q;
   logic         read_in_q;
   logic         load_out_q;
   logic         load_dir_q;

   logic         req_ready_d;
   logic         rsp_valid_d;
   logic         rsp_err_d;
   logic [N-1:0] rsp_rdata_d;
   logic [N-1:0] bus_out_d;
   logic         bus_oe_d;
   logic         read_in_d;
   logic         load_out_d;
   logic         load_dir_d;

   // req_ready is high exactly in IDLE, so the handshake reduces to the state check.
   assign accept      = (state == IDLE) && sif.req_valid;
   assign is_write_ok = sif.req_write && ((sif.req_addr == ADDR_OUT) || (sif.req_addr == ADDR_DIR));
   assign is_pin_read = !sif.req_write && (sif.req_addr == ADDR_PIN);
   assign wdata_cur   = accept ? sif.req_wdata : wdata_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= sif.req_addr;
         wdata_q <= sif.req_wdata;
      end
   end

`ifdef GPIO_SHADOW_READBACK_EN
   logic [N-1:0] shadow_out;
   logic [N-1:0] shadow_dir;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow_out <= '0;
         shadow_dir <= '0;
      end else if (state == W_STROBE) begin
         if (addr_q == ADDR_OUT) begin
            shadow_out <= wdata_q;
         end else if (addr_q == ADDR_DIR) begin
            shadow_dir <= wdata_q;
         end
      end
   end

   assign shadow_hit   = !sif.req_write && ((sif.req_addr == ADDR_OUT) || (sif.req_addr == ADDR_DIR));
   assign shadow_rdata = (sif.req_addr == ADDR_OUT) ? shadow_out : shadow_dir;
`else
   assign shadow_hit   = 1'b0;
   assign shadow_rdata = '0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (is_write_ok) begin
                  next_state = W_SETUP;
               end else if (is_pin_read) begin
                  next_state = R_DRIVE;
               end else begin
                  next_state = RESP;
               end
            end
         end
         W_SETUP:  next_state = W_STROBE;
         W_STROBE: next_state = W_HOLD;
         W_HOLD:   next_state = RESP;
         R_DRIVE:  next_state = R_SAMPLE;
         R_SAMPLE: next_state = RESP;
         RESP: begin
            if (sif.rsp_ready) begin
               next_state = IDLE;
            end
         end
         default:  next_state = IDLE;
      endcase
   end

   // Outputs are decoded from next_state and registered, so every strobe and bus
   // signal comes straight from a flop and clears with the asynchronous reset.
   always_comb begin
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      bus_out_d   = '0;
      bus_oe_d    = 1'b0;
      read_in_d   = 1'b0;
      load_out_d  = 1'b0;
      load_dir_d  = 1'b0;
      unique case (next_state)
         IDLE: begin
            req_ready_d = 1'b1;
         end
         W_SETUP, W_HOLD: begin
            bus_oe_d  = 1'b1;
            bus_out_d = wdata_cur;
         end
         W_STROBE: begin
            bus_oe_d   = 1'b1;
            bus_out_d  = wdata_cur;
            load_out_d = (addr_q == ADDR_OUT);
            load_dir_d = (addr_q == ADDR_DIR);
         end
         R_DRIVE, R_SAMPLE: begin
            read_in_d = 1'b1;
         end
         RESP: begin
            rsp_valid_d = 1'b1;
            if (state == RESP) begin
               rsp_err_d   = rsp_err_q;
               rsp_rdata_d = rsp_rdata_q;
            end else if (state == R_SAMPLE) begin
               rsp_rdata_d = sif.bus_in;
            end else if (state == IDLE) begin
               rsp_err_d   = !shadow_hit;
               rsp_rdata_d = shadow_hit ? shadow_rdata : '0;
            end
         end
         default: begin
            req_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         bus_out_q   <= '0;
         bus_oe_q    <= 1'b0;
         read_in_q   <= 1'b0;
         load_out_q  <= 1'b0;
         load_dir_q  <= 1'b0;
      end else begin
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         bus_out_q   <= bus_out_d;
         bus_oe_q    <= bus_oe_d;
         read_in_q   <= read_in_d;
         load_out_q  <= load_out_d;
         load_dir_q  <= load_dir_d;
      end
   end

   assign sif.req_ready = req_ready_q;
   assign sif.rsp_valid = rsp_valid_q;
   assign sif.rsp_err   = rsp_err_q;
   assign sif.rsp_rdata = rsp_rdata_q;
   assign sif.bus_out   = bus_out_q;
   assign sif.bus_oe    = bus_oe_q;
   assign sif.read_in   = read_in_q;
   assign sif.load_out  = load_out_q;
   assign sif.load_dir  = load_dir_q;

endmodule

// File: tb/tb_gpio_bus_sequencer.sv
// Directed bench for gpio_bus_sequencer: a reference model pushes expected responses and
// per-cycle strobe patterns to a scoreboard that is popped when the DUT responds.
module tb_gpio_bus_sequencer;
   import gpio_pkg::*;

   localparam int N = GPIO_N;

   // Bit k of each pattern is the expected value in the k-th cycle after the accept edge.
   typedef struct packed {
      logic [N-1:0] rdata;
      logic         err;
      logic [3:0]   lat;
      logic [15:0]  oe;
      logic [15:0]  lo;
      logic [15:0]  ld;
      logic [15:0]  ri;
   } exp_t;

   logic         clock  = 1'b0;
   logic         reset  = 1'b1;
   logic [N-1:0] pin_val = '0;
   logic [N-1:0] sh_out  = '0;
   logic [N-1:0] sh_dir  = '0;
   int           checks = 0;
   int           errors = 0;
   exp_t         sb[$];

   gpio_bus_sequencer_if #(.N(N)) s ();

   gpio_bus_sequencer #(.N(N)) dut (
      .clock (clock),
      .reset (reset),
      .sif   (s)
   );

   always #5 clock = ~clock;

   assign s.bus_in = s.read_in ? pin_val : '0;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic wr, input logic [1:0] addr, input logic [N-1:0] wd);
      exp_t e;
      e = '0;
      if (wr && (addr == ADDR_OUT || addr == ADDR_DIR)) begin
         e.lat = 4'd4;
         e.oe  = 16'h000E;
         e.lo  = (addr == ADDR_OUT) ? 16'h0004 : 16'h0000;
         e.ld  = (addr == ADDR_DIR) ? 16'h0004 : 16'h0000;
      end else if (!wr && addr == ADDR_PIN) begin
         e.lat   = 4'd3;
         e.ri    = 16'h0006;
         e.rdata = pin_val;
      end else begin
         e.lat = 4'd1;
`ifdef GPIO_SHADOW_READBACK_EN
         if (!wr && (addr == ADDR_OUT || addr == ADDR_DIR)) begin
            e.rdata = (addr == ADDR_OUT) ? sh_out : sh_dir;
         end else begin
            e.err = 1'b1;
         end
`else
         e.err = 1'b1;
`endif
      end
      if (wd == '0) begin
         e.rdata = e.rdata;
      end
      return e;
   endfunction

   task automatic apply_stimulus(input logic wr, input logic [1:0] addr, input logic [N-1:0] wd,
                                 input int hold);
      exp_t        e;
      exp_t        got;
      logic [15:0] oe_v, lo_v, ld_v, ri_v, rr_v, cf_v, bo_v;
      int          cyc;
      logic        seen;

      e = model(wr, addr, wd);
      sb.push_back(e);
      if (wr && addr == ADDR_OUT) sh_out = wd;
      if (wr && addr == ADDR_DIR) sh_dir = wd;

      @(negedge clock);
      s.req_valid = 1'b1;
      s.req_write = wr;
      s.req_addr  = addr;
      s.req_wdata = wd;
      s.rsp_ready = (hold == 0);

      oe_v = '0; lo_v = '0; ld_v = '0; ri_v = '0; rr_v = '0; cf_v = '0; bo_v = '0;
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 12) begin
         @(negedge clock);
         cyc++;
         if (cyc == 1) s.req_valid = 1'b0;
         oe_v[cyc] = s.bus_oe;
         lo_v[cyc] = s.load_out;
         ld_v[cyc] = s.load_dir;
         ri_v[cyc] = s.read_in;
         rr_v[cyc] = s.req_ready;
         cf_v[cyc] = s.bus_oe & s.read_in;
         bo_v[cyc] = s.bus_oe && (s.bus_out !== wd);
         seen      = s.rsp_valid;
      end

      if (sb.size() > 0) begin
         got = sb.pop_front();
      end else begin
         got = '0;
      end
      check_output("latency",   32'(cyc),      32'(got.lat));
      check_output("bus_oe",    32'(oe_v),     32'(got.oe));
      check_output("load_out",  32'(lo_v),     32'(got.lo));
      check_output("load_dir",  32'(ld_v),     32'(got.ld));
      check_output("read_in",   32'(ri_v),     32'(got.ri));
      check_output("req_ready_busy", 32'(rr_v), 32'(0));
      check_output("contention", 32'(cf_v),    32'(0));
      check_output("bus_out",   32'(bo_v),     32'(0));
      check_output("rsp_rdata", 32'(s.rsp_rdata), 32'(got.rdata));
      check_output("rsp_err",   32'(s.rsp_err),   32'(got.err));

      // A competing request is offered while the response is back-pressured.
      for (int i = 0; i < hold; i++) begin
         if (i == 0) begin
            s.req_valid = 1'b1;
            s.req_write = 1'b1;
            s.req_addr  = ADDR_OUT;
            s.req_wdata = '1;
         end
         @(negedge clock);
         check_output("hold_valid", 32'(s.rsp_valid), 32'(1));
         check_output("hold_rsp",   32'({s.rsp_rdata, s.rsp_err}), 32'({got.rdata, got.err}));
         check_output("hold_ready", 32'(s.req_ready), 32'(0));
         check_output("hold_quiet", 32'({s.bus_oe, s.read_in, s.load_out, s.load_dir}), 32'(0));
      end
      s.req_valid = 1'b0;
      s.rsp_ready = 1'b1;

      @(negedge clock);
      check_output("post_handshake", 32'({s.rsp_valid, s.req_ready}), 32'(2'b01));
   endtask

   initial begin
      logic [31:0] r;

      s.req_valid = 1'b0;
      s.req_write = 1'b0;
      s.req_addr  = '0;
      s.req_wdata = '0;
      s.rsp_ready = 1'b1;

      repeat (2) @(negedge clock);
      check_output("reset_ready", 32'(s.req_ready), 32'(1));
      check_output("reset_outputs", 32'({s.rsp_valid, s.rsp_err, s.rsp_rdata, s.bus_out,
                                         s.bus_oe, s.read_in, s.load_out, s.load_dir}), 32'(0));
      reset = 1'b0;

      apply_stimulus(1'b1, ADDR_OUT, 4'b1010, 0);
      apply_stimulus(1'b1, ADDR_DIR, 4'b0011, 0);
      pin_val = 4'b1010;
      apply_stimulus(1'b0, ADDR_PIN, 4'b0000, 0);
      apply_stimulus(1'b0, 2'd3,     4'b0000, 0);
      apply_stimulus(1'b1, ADDR_PIN, 4'b1111, 0);
      apply_stimulus(1'b1, 2'd3,     4'b0110, 0);
      pin_val = 4'b0101;
      apply_stimulus(1'b0, ADDR_PIN, 4'b0000, 6);
      apply_stimulus(1'b0, ADDR_OUT, 4'b0000, 0);
      apply_stimulus(1'b0, ADDR_DIR, 4'b0000, 0);

      // Abort a write while LOAD_OUT is pulsing.
      @(negedge clock);
      s.req_valid = 1'b1;
      s.req_write = 1'b1;
      s.req_addr  = ADDR_OUT;
      s.req_wdata = 4'b1100;
      @(negedge clock);
      s.req_valid = 1'b0;
      @(posedge clock);
      #1;
      check_output("abort_strobe", 32'({s.load_out, s.bus_oe}), 32'(2'b11));
      #2 reset = 1'b1;
      #1;
      check_output("abort_async", 32'({s.load_out, s.bus_oe, s.rsp_valid, s.req_ready}), 32'(4'b0001));
      @(negedge clock);
      reset  = 1'b0;
      sh_out = '0;
      sh_dir = '0;
      repeat (3) @(negedge clock);
      check_output("abort_no_rsp", 32'({s.rsp_valid, s.req_ready, s.bus_oe}), 32'(3'b010));

      apply_stimulus(1'b1, ADDR_OUT, 4'b1010, 0);
      apply_stimulus(1'b0, ADDR_OUT, 4'b0000, 0);

      for (int k = 0; k < 6; k++) begin
         r = $urandom;
         pin_val = r[N-1:0];
         r = $urandom;
         apply_stimulus(r[8], r[5:4], r[N-1:0], 0);
      end

      check_output("scoreboard_empty", 32'(sb.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule
